tt_slot_mux: RTL and testbench
==============================

# tt_slot_mux

Parametrised, registered successor to the combinational tiny-tapeout design selector in the user area. It broadcasts synchronised pad inputs to `NUM_SLOTS` small designs and returns the selected slot's outputs to the pads through a register. Slot selection changes only through a valid/ready handshake, and every switch runs a reset sequence on the shared slot inputs. Sits between the caravel IO pads and the `tt_*` project instances.

## Interface
Parameters:
- `NUM_SLOTS`, default 8. Number of attached designs, 2..16.
- `IO_W`, default 8. Width of each slot's in/out bus.
- `SYNC_STAGES`, default 2. Flop stages on the pad input path, 2..3.
- `RST_CYCLES`, default 4. Cycles the slot reset bit is held on each switch, 1..255.
- `RST_BIT`, default 1. Index within the slot input bus that is the slot reset.

Derived: `SEL_W = $clog2(NUM_SLOTS)`.

Ports:
- `clock` in 1. Single clock.
- `reset` in 1. Asynchronous, active-high.
- `sel_i` in `SEL_W`. Requested slot.
- `sel_valid_i` in 1. Select request valid.
- `sel_ready_o` out 1. Select accepted when valid and ready are both high.
- `sel_err_o` out 1. One-cycle pulse when the request is out of range.
- `active_sel_o` out `SEL_W`. Currently connected slot.
- `pad_in` in `IO_W`. Asynchronous pad inputs.
- `slot_in` out `IO_W`. Broadcast to all slots.
- `slot_out` in `NUM_SLOTS*IO_W`. Slot k drives bits `[k*IO_W +: IO_W]`.
- `pad_out` out `IO_W`. Registered output of the selected slot.

## Operation
- FSM has two states: HOLD and RUN.
- Reset values:
  - State is HOLD with the counter at `RST_CYCLES`.
  - `active_sel_o=0`, `pad_out=0`, `sel_ready_o=0`, `sel_err_o=0`.
  - `slot_in` has only bit `RST_BIT` set (8'h02 at defaults).
  - All synchroniser flops are 0.
- HOLD:
  - `slot_in` has only `RST_BIT` set and `pad_out=0`.
  - The counter decrements each cycle; on reaching 1 the FSM goes to RUN.
  - `sel_ready_o=0`, and `sel_valid_i` is ignored.
- RUN:
  - `slot_in` equals the last synchroniser stage.
  - `pad_out` registers the `slot_out` slice selected by `active_sel_o`.
  - `sel_ready_o=1`.
- Accept with `sel_i < NUM_SLOTS`:
  - `active_sel_o` loads `sel_i`, the counter loads `RST_CYCLES`, and the FSM goes to HOLD.
  - Reselecting the current slot is legal and only resets it.
- Accept with `sel_i >= NUM_SLOTS` (only possible when `NUM_SLOTS` is not a power of 2):
  - `sel_err_o` pulses for one cycle.
  - The FSM stays in RUN and `active_sel_o` is unchanged.
- The synchronisers run continuously in both states, so the first RUN cycle presents already-settled pad data.
- Asserting `reset` mid-sequence forces the reset values immediately. After deassertion a full `RST_CYCLES` HOLD on slot 0 follows.

## Timing
- Pad input path: a change on `pad_in` appears on `slot_in` after `SYNC_STAGES` rising edges while in RUN.
- Output path: `slot_out` to `pad_out` takes 1 cycle of latency.
- Switch accepted at edge k:
  - At k+1: `active_sel_o` is new, `pad_out=0`, and the reset bit is high.
  - HOLD lasts exactly `RST_CYCLES` cycles.
  - At edge k+`RST_CYCLES`: `sel_ready_o` rises.
  - At edge k+`RST_CYCLES`+1: `pad_out` carries the new slot's data.
- After reset deassertion: `sel_ready_o` rises at edge `RST_CYCLES`.
- `sel_err_o` is high in the cycle after the accepting edge.
- Back-to-back requests: valid held high across a switch is accepted again at the first RUN cycle.

## Configuration
- `TT_SLOT_MUX_ACT_EN` defined:
  - Adds output `act_cnt_o` [15:0], which counts cycles in RUN where the next `pad_out` differs from the current value.
  - The count saturates at 16'hFFFF.
  - It clears on `reset` and on every accepted valid select.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Package `tt_slot_mux_pkg` holds:
  - the state enum (HOLD, RUN);
  - the counter width constant (8 bits);
  - the saturating counter width (16).
- Sub-module `tt_sync_bus` is an `IO_W`-wide synchroniser with `SYNC_STAGES` flops, async reset to 0, instantiated once.
- The output mux, FSM and counter live in `tt_slot_mux`.

## Test plan
- Power-on: reset, then release → `slot_in`=8'h02 for 4 cycles, `sel_ready_o` rises at cycle 4, `pad_out`=slot 0 data at cycle 5.
- Switch to slot 5 with slot 5 driving 8'hA5 → `pad_out`=0 for 4 cycles, then 8'hA5; `active_sel_o`=5; `sel_ready_o` low exactly 4 cycles.
- `NUM_SLOTS`=6, request 7 → one `sel_err_o` pulse, `active_sel_o` unchanged, no reset bit pulse, `pad_out` uninterrupted.
- Pad input 8'h3C applied in RUN → `slot_in`=8'h3C exactly 2 edges later; in HOLD `slot_in` stays 8'h02.
- Assert `reset` mid-HOLD after switching to slot 3 → `active_sel_o`=0 immediately, then a full HOLD, then RUN on slot 0.
- With `TT_SLOT_MUX_ACT_EN`, toggle slot 0 output every cycle for 10 cycles → `act_cnt_o`=10; a reselect clears it to 0.

Source files
------------

// File: rtl/tt_slot_mux_pkg.sv
// rtl/tt_slot_mux_pkg.sv - shared types and widths for the tiny-tapeout slot selector
//
// Holds the HOLD/RUN state encoding, the width of the slot-reset hold
// counter, and the width of the optional output-activity counter.

package tt_slot_mux_pkg;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Hold counter width; RST_CYCLES must fit (1..255).
    localparam int CNT_W = 8;

    // Saturating activity counter width.
    localparam int ACT_W = 16;

endpackage

// File: rtl/tt_sync_bus.sv
// rtl/tt_sync_bus.sv - multi-bit pad input synchroniser
//
// Purpose: passes an asynchronous bus through STAGES flop stages. Each bit
// is synchronised independently; the bus is not treated as a coherent word.
// Ports:
//   clock  - sampling clock
//   reset  - asynchronous active-high reset, clears every stage to 0
//   d_i    - asynchronous input bus [W-1:0]
//   q_o    - output of the last stage [W-1:0]

module tt_sync_bus #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [STAGES];
    logic [W-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = d_i;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/tt_slot_mux.sv
// rtl/tt_slot_mux.sv - registered tiny-tapeout design selector with per-switch slot reset
//
// Purpose: broadcasts synchronised pad inputs to NUM_SLOTS designs and
// registers the selected design's outputs back to the pads. Selection
// changes through a valid/ready handshake; every accepted switch holds the
// slot reset bit for RST_CYCLES cycles before the new slot is connected.
// Optional feature macro: TT_SLOT_MUX_ACT_EN adds act_cnt_o, a saturating
// count of RUN cycles in which pad_out is about to change.
// Ports:
//   clock, reset  - clock and asynchronous active-high reset
//   sel_i         - requested slot [SEL_W-1:0]
//   sel_valid_i   - request valid; accepted when sel_ready_o is also high
//   sel_ready_o   - high while in RUN
//   sel_err_o     - one-cycle pulse after an out-of-range request is accepted
//   active_sel_o  - currently connected slot
//   pad_in        - asynchronous pad inputs [IO_W-1:0]
//   slot_in       - broadcast to all slots [IO_W-1:0]
//   slot_out      - slot k drives [k*IO_W +: IO_W]
//   pad_out       - registered output of the selected slot
//   act_cnt_o     - (TT_SLOT_MUX_ACT_EN only) activity count [15:0]

module tt_slot_mux
    import tt_slot_mux_pkg::*;
#(
    parameter int NUM_SLOTS   = 8,
    parameter int IO_W        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RST_CYCLES  = 4,
    parameter int RST_BIT     = 1,
    localparam int SEL_W      = $clog2(NUM_SLOTS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic                      sel_valid_i,
    output logic                      sel_ready_o,
    output logic                      sel_err_o,
    output logic [SEL_W-1:0]          active_sel_o,
    input  logic [IO_W-1:0]           pad_in,
    output logic [IO_W-1:0]           slot_in,
    input  logic [NUM_SLOTS*IO_W-1:0] slot_out,
    output logic [IO_W-1:0]           pad_out
`ifdef TT_SLOT_MUX_ACT_EN
   ,output logic [ACT_W-1:0]          act_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] RST_CNT    = CNT_W'(RST_CYCLES);
    localparam logic [IO_W-1:0]  RST_MASK   = IO_W'(1) << RST_BIT;
    localparam logic [SEL_W:0]   SLOT_LIMIT = (SEL_W+1)'(NUM_SLOTS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] active_sel_q, active_sel_d;
    logic [IO_W-1:0]  pad_out_q, pad_out_d;
    logic             sel_err_q, sel_err_d;

    logic [IO_W-1:0]  pad_sync;
    logic [IO_W-1:0]  slot_sel;
    logic             sel_fire;
    logic             sel_in_range;

    // The synchroniser is never gated, so pad data is already settled when
    // a slot leaves HOLD.
    tt_sync_bus #(
        .W      (IO_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (pad_in),
        .q_o   (pad_sync)
    );

    assign slot_sel     = slot_out[active_sel_q*IO_W +: IO_W];
    assign sel_fire     = sel_valid_i && (state_q == ST_RUN);
    // Extended by one bit so the comparison holds when NUM_SLOTS is a power of 2.
    assign sel_in_range = ({1'b0, sel_i} < SLOT_LIMIT);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        active_sel_d = active_sel_q;
        pad_out_d    = '0;
        sel_err_d    = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                pad_out_d = slot_sel;
                if (sel_fire) begin
                    if (sel_in_range) begin
                        // Output drops to 0 on the accepting edge so the old
                        // slot's data never leaks past the switch.
                        active_sel_d = sel_i;
                        cnt_d        = RST_CNT;
                        state_d      = ST_HOLD;
                        pad_out_d    = '0;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = RST_CNT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            cnt_q        <= RST_CNT;
            active_sel_q <= '0;
            pad_out_q    <= '0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            active_sel_q <= active_sel_d;
            pad_out_q    <= pad_out_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign sel_ready_o  = (state_q == ST_RUN);
    assign sel_err_o    = sel_err_q;
    assign active_sel_o = active_sel_q;
    assign pad_out      = pad_out_q;
    assign slot_in      = (state_q == ST_RUN) ? pad_sync : RST_MASK;

`ifdef TT_SLOT_MUX_ACT_EN
    logic [ACT_W-1:0] act_cnt_q, act_cnt_d;

    always_comb begin
        act_cnt_d = act_cnt_q;
        if (sel_fire && sel_in_range) begin
            act_cnt_d = '0;
        end else if ((state_q == ST_RUN) && (pad_out_d != pad_out_q) && (act_cnt_q != '1)) begin
            act_cnt_d = act_cnt_q + ACT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act_cnt_q <= '0;
        end else begin
            act_cnt_q <= act_cnt_d;
        end
    end

    assign act_cnt_o = act_cnt_q;
`endif

endmodule

// File: tb/tb_tt_slot_mux.sv
// tb/tb_tt_slot_mux.sv - directed self-checking bench for tt_slot_mux (NUM_SLOTS=6)

module tb_tt_slot_mux;

    localparam int NS    = 6;
    localparam int IO_W  = 8;
    localparam int SEL_W = 3;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [SEL_W-1:0]     sel_i;
    logic                 sel_valid_i;
    logic                 sel_ready_o;
    logic                 sel_err_o;
    logic [SEL_W-1:0]     active_sel_o;
    logic [IO_W-1:0]      pad_in;
    logic [IO_W-1:0]      slot_in;
    logic [NS*IO_W-1:0]   slot_out;
    logic [IO_W-1:0]      pad_out;
`ifdef TT_SLOT_MUX_ACT_EN
    logic [15:0]          act_cnt_o;
`endif

    logic [IO_W-1:0]      slot_val [NS];

    int n_checks = 0;
    int n_errors = 0;
    int low;

    always #5 clock = ~clock;

    for (genvar k = 0; k < NS; k++) begin : g_slot
        assign slot_out[k*IO_W +: IO_W] = slot_val[k];
    end

    tt_slot_mux #(
        .NUM_SLOTS   (NS),
        .IO_W        (IO_W),
        .SYNC_STAGES (2),
        .RST_CYCLES  (4),
        .RST_BIT     (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sel_i        (sel_i),
        .sel_valid_i  (sel_valid_i),
        .sel_ready_o  (sel_ready_o),
        .sel_err_o    (sel_err_o),
        .active_sel_o (active_sel_o),
        .pad_in       (pad_in),
        .slot_in      (slot_in),
        .slot_out     (slot_out),
        .pad_out      (pad_out)
`ifdef TT_SLOT_MUX_ACT_EN
       ,.act_cnt_o    (act_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        sel_i       = '0;
        sel_valid_i = 1'b0;
        pad_in      = '0;
        slot_val[0] = 8'h11;
        slot_val[1] = 8'h22;
        slot_val[2] = 8'h33;
        slot_val[3] = 8'h44;
        slot_val[4] = 8'h55;
        slot_val[5] = 8'hA5;

        // Reset state
        step();
        step();
        check("rst_slot_in", slot_in, 8'h02);
        check("rst_ready", sel_ready_o, 1'b0);
        check("rst_err", sel_err_o, 1'b0);
        check("rst_active", active_sel_o, 3'd0);
        check("rst_pad_out", pad_out, 8'h00);

        // Power-on HOLD then RUN on slot 0
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("por_hold_slot_in", slot_in, 8'h02);
            check("por_hold_ready", sel_ready_o, 1'b0);
            check("por_hold_pad_out", pad_out, 8'h00);
        end
        step();
        check("por_ready_edge4", sel_ready_o, 1'b1);
        check("por_pad_out_edge4", pad_out, 8'h00);
        step();
        check("por_pad_out_edge5", pad_out, 8'h11);

        // Pad input path latency in RUN
        pad_in = 8'h3C;
        step();
        check("sync_edge1", slot_in, 8'h00);
        step();
        check("sync_edge2", slot_in, 8'h3C);

        // Switch to slot 5
        sel_i       = 3'd5;
        sel_valid_i = 1'b1;
        step();
        sel_valid_i = 1'b0;
        check("sw5_active", active_sel_o, 3'd5);
        low = 0;
        for (int i = 0; i < 10 && !sel_ready_o; i++) begin
            low++;
            check("sw5_hold_pad_out", pad_out, 8'h00);
            check("sw5_hold_slot_in", slot_in, 8'h02);
            step();
        end
        check("sw5_ready_low_cycles", low, 4);
        check("sw5_ready", sel_ready_o, 1'b1);
        check("sw5_slot_in_settled", slot_in, 8'h3C);
        check("sw5_pad_out_first_run", pad_out, 8'h00);
        step();
        check("sw5_pad_out", pad_out, 8'hA5);

        // Output path is registered
        slot_val[5] = 8'h5A;
        check("out_latency_before", pad_out, 8'hA5);
        step();
        check("out_latency_after", pad_out, 8'h5A);

        // Out-of-range requests
        sel_i       = 3'd7;
        sel_valid_i = 1'b1;
        step();
        sel_valid_i = 1'b0;
        check("err7_pulse", sel_err_o, 1'b1);
        check("err7_active", active_sel_o, 3'd5);
        check("err7_ready", sel_ready_o, 1'b1);
        check("err7_slot_in", slot_in, 8'h3C);
        check("err7_pad_out", pad_out, 8'h5A);
        step();
        check("err7_pulse_end", sel_err_o, 1'b0);
        check("err7_pad_out_after", pad_out, 8'h5A);
        sel_i       = 3'd6;
        sel_valid_i = 1'b1;
        step();
        sel_valid_i = 1'b0;
        check("err6_pulse", sel_err_o, 1'b1);
        check("err6_active", active_sel_o, 3'd5);
        step();

        // Back-to-back: valid held across a switch
        sel_i       = 3'd2;
        sel_valid_i = 1'b1;
        step();
        check("b2b_first_active", active_sel_o, 3'd2);
        sel_i = 3'd4;
        repeat (3) step();
        check("b2b_hold_ready", sel_ready_o, 1'b0);
        step();
        check("b2b_ready_rise", sel_ready_o, 1'b1);
        check("b2b_still_2", active_sel_o, 3'd2);
        step();
        sel_valid_i = 1'b0;
        check("b2b_second_active", active_sel_o, 3'd4);
        check("b2b_second_ready", sel_ready_o, 1'b0);
        repeat (5) step();
        check("b2b_pad_out", pad_out, 8'h55);

        // Reset in the middle of HOLD
        sel_i       = 3'd3;
        sel_valid_i = 1'b1;
        step();
        sel_valid_i = 1'b0;
        check("mid_active3", active_sel_o, 3'd3);
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_active", active_sel_o, 3'd0);
        check("mid_rst_slot_in", slot_in, 8'h02);
        check("mid_rst_ready", sel_ready_o, 1'b0);
        step();
        reset = 1'b0;
        repeat (3) step();
        check("mid_hold_ready", sel_ready_o, 1'b0);
        step();
        check("mid_ready", sel_ready_o, 1'b1);
        step();
        check("mid_pad_out", pad_out, 8'h11);
        check("mid_active0", active_sel_o, 3'd0);

`ifdef TT_SLOT_MUX_ACT_EN
        // Activity counter
        slot_val[0] = 8'h00;
        sel_i       = 3'd0;
        sel_valid_i = 1'b1;
        step();
        sel_valid_i = 1'b0;
        check("act_clear_on_sel", act_cnt_o, 16'd0);
        repeat (4) step();
        check("act_ready", sel_ready_o, 1'b1);
        for (int i = 0; i < 10; i++) begin
            slot_val[0] = (i % 2 == 0) ? 8'hFF : 8'h00;
            step();
        end
        repeat (2) step();
        check("act_count10", act_cnt_o, 16'd10);
        sel_valid_i = 1'b1;
        step();
        sel_valid_i = 1'b0;
        check("act_reselect_clear", act_cnt_o, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
